// File: rtl/ysyx_25040111_trap_seq.sv
// ---------------------------------------------------------------------------
// ysyx_25040111_trap_seq
//
// Sequences machine-mode trap entry (ecall) and trap return (mret) through a
// single-port style CSR interface, then hands the new fetch PC to fetch.
//
//   ecall: IDLE -> W_EPC -> W_CAUSE -> R_STAT -> W_STAT -> R_VEC -> REDIR
//   mret : IDLE -> R_EPC -> R_STAT -> W_STAT -> REDIR
//
// Ports
//   clk            : single clock, rising edge
//   reset          : asynchronous, active-low (0 = in reset)
//   trap_valid     : trap request from decode (held until trap_ready)
//   trap_type      : 01 = ecall, 10 = mret, others ignored
//   trap_pc        : PC of the trapping instruction
//   trap_ready     : high only in IDLE; request taken when also trap_valid
//   csr_wen/waddr/wdata : CSR write port
//   csr_ren/raddr  : CSR read request; csr_rdata returns combinationally
//   csr_jtype      : trap-cause strobe, 01 makes the CSR file set mcause=11
//   redirect_valid/pc/ready : new fetch PC handshake
//   busy           : high in every state except IDLE
//
// All outputs are decoded from the state and internal registers only.
// ---------------------------------------------------------------------------
module ysyx_25040111_trap_seq #(
   parameter logic [31:0] TVEC_MASK = 32'hFFFF_FFFC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        trap_valid,
   input  logic [1:0]  trap_type,
   input  logic [31:0] trap_pc,
   output logic        trap_ready,
   output logic        csr_wen,
   output logic [11:0] csr_waddr,
   output logic [31:0] csr_wdata,
   output logic        csr_ren,
   output logic [11:0] csr_raddr,
   input  logic [31:0] csr_rdata,
   output logic [1:0]  csr_jtype,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   input  logic        redirect_ready,
   output logic        busy
);

   localparam logic [1:0]  TYPE_ECALL = 2'b01;
   localparam logic [1:0]  TYPE_MRET  = 2'b10;
   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      W_EPC   = 3'd1,
      W_CAUSE = 3'd2,
      R_STAT  = 3'd3,
      W_STAT  = 3'd4,
      R_VEC   = 3'd5,
      R_EPC   = 3'd6,
      REDIR   = 3'd7
   } state_t;

   state_t      state_reg, state_next;
   logic [31:0] pc_reg;
   logic [1:0]  type_reg;
   logic [31:0] mstatus_reg;
   logic [31:0] target_reg;
   logic [31:0] mstatus_mod;
   logic        accept;

   // Only ecall and mret start a sequence; other encodings are dropped.
   assign accept = (state_reg == IDLE) && trap_valid &&
                   ((trap_type == TYPE_ECALL) || (trap_type == TYPE_MRET));

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Datapath registers: request latch, mstatus snapshot and redirect target
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_reg      <= 32'h0;
         type_reg    <= 2'b00;
         mstatus_reg <= 32'h0;
         target_reg  <= 32'h0;
      end else begin
         if (accept) begin
            pc_reg   <= trap_pc;
            type_reg <= trap_type;
         end
         if (state_reg == R_STAT) begin
            mstatus_reg <= csr_rdata;
         end
         if (state_reg == R_VEC) begin
            target_reg <= csr_rdata & TVEC_MASK;
         end
         if (state_reg == R_EPC) begin
            target_reg <= csr_rdata;
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               state_next = (trap_type == TYPE_ECALL) ? W_EPC : R_EPC;
            end
         end
         W_EPC:   state_next = W_CAUSE;
         W_CAUSE: state_next = R_STAT;
         R_STAT:  state_next = W_STAT;
         // ecall still needs the vector; mret already has mepc as target
         W_STAT:  state_next = (type_reg == TYPE_ECALL) ? R_VEC : REDIR;
         R_VEC:   state_next = REDIR;
         R_EPC:   state_next = R_STAT;
         REDIR: begin
            if (redirect_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // mstatus update: ecall stacks MIE into MPIE, mret restores it.
   // MPP is forced to machine mode in both directions (M-only core).
   always_comb begin
      mstatus_mod = mstatus_reg;
      if (type_reg == TYPE_ECALL) begin
         mstatus_mod[7] = mstatus_reg[3];
         mstatus_mod[3] = 1'b0;
      end else begin
         mstatus_mod[3] = mstatus_reg[7];
         mstatus_mod[7] = 1'b1;
      end
      mstatus_mod[12:11] = 2'b11;
   end

   // Output decode
   always_comb begin
      trap_ready     = (state_reg == IDLE);
      busy           = (state_reg != IDLE);
      csr_wen        = 1'b0;
      csr_waddr      = 12'h0;
      csr_wdata      = 32'h0;
      csr_ren        = 1'b0;
      csr_raddr      = 12'h0;
      csr_jtype      = 2'b00;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      case (state_reg)
         W_EPC: begin
            csr_wen   = 1'b1;
            csr_waddr = CSR_MEPC;
            csr_wdata = pc_reg;
         end
         W_CAUSE: begin
            csr_jtype = 2'b01;
         end
         R_STAT: begin
            csr_ren   = 1'b1;
            csr_raddr = CSR_MSTATUS;
         end
         W_STAT: begin
            csr_wen   = 1'b1;
            csr_waddr = CSR_MSTATUS;
            csr_wdata = mstatus_mod;
         end
         R_VEC: begin
            csr_ren   = 1'b1;
            csr_raddr = CSR_MTVEC;
         end
         R_EPC: begin
            csr_ren   = 1'b1;
            csr_raddr = CSR_MEPC;
         end
         REDIR: begin
            redirect_valid = 1'b1;
            redirect_pc    = target_reg;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ysyx_25040111_trap_seq.sv
// ---------------------------------------------------------------------------
// Bench for ysyx_25040111_trap_seq. A small CSR file model answers reads and
// absorbs writes. Directed stimulus pushes the expected CSR writes, cause
// strobes and redirects into a queue; a monitor on the falling edge pops and
// compares whenever the DUT presents one of those events.
// ---------------------------------------------------------------------------
module tb_ysyx_25040111_trap_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        trap_valid;
   logic [1:0]  trap_type;
   logic [31:0] trap_pc;
   logic        trap_ready;
   logic        csr_wen;
   logic [11:0] csr_waddr;
   logic [31:0] csr_wdata;
   logic        csr_ren;
   logic [11:0] csr_raddr;
   logic [31:0] csr_rdata;
   logic [1:0]  csr_jtype;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        redirect_ready;
   logic        busy;

   always #5 clk = ~clk;

   ysyx_25040111_trap_seq #(.TVEC_MASK(32'hFFFF_FFFC)) dut (
      .clk            (clk),
      .reset          (reset),
      .trap_valid     (trap_valid),
      .trap_type      (trap_type),
      .trap_pc        (trap_pc),
      .trap_ready     (trap_ready),
      .csr_wen        (csr_wen),
      .csr_waddr      (csr_waddr),
      .csr_wdata      (csr_wdata),
      .csr_ren        (csr_ren),
      .csr_raddr      (csr_raddr),
      .csr_rdata      (csr_rdata),
      .csr_jtype      (csr_jtype),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .redirect_ready (redirect_ready),
      .busy           (busy)
   );

   // ---------------- CSR file model ----------------
   logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;
   logic        ld_en;
   logic [11:0] ld_addr;
   logic [31:0] ld_data;

   always_comb begin
      csr_rdata = 32'h0;
      case (csr_raddr)
         12'h300: csr_rdata = m_mstatus;
         12'h305: csr_rdata = m_mtvec;
         12'h341: csr_rdata = m_mepc;
         default: csr_rdata = 32'h0;
      endcase
   end

   always @(posedge clk) begin
      if (ld_en) begin
         case (ld_addr)
            12'h300: m_mstatus <= ld_data;
            12'h305: m_mtvec   <= ld_data;
            12'h341: m_mepc    <= ld_data;
            default: m_mcause  <= ld_data;
         endcase
      end else begin
         if (csr_wen) begin
            case (csr_waddr)
               12'h300: m_mstatus <= csr_wdata;
               12'h305: m_mtvec   <= csr_wdata;
               12'h341: m_mepc    <= csr_wdata;
               default: ;
            endcase
         end
         if (csr_jtype == 2'b01) m_mcause <= 32'd11;
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      int          kind;   // 0 = CSR write, 1 = cause strobe, 2 = redirect
      logic [11:0] addr;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   sb_n = 0;
   int   sb_fail = 0;
   int   n_vec = 0;
   int   n_fail = 0;

   task automatic push(input int k, input logic [11:0] a, input logic [31:0] d);
      exp_t e;
      e.kind = k;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic sb_check(input int k, input logic [11:0] a, input logic [31:0] d,
                           input string name);
      exp_t e;
      sb_n++;
      if (exp_q.size() == 0) begin
         sb_fail++;
         $display("FAIL %s: unexpected event addr=%h data=%h, required no activity", name, a, d);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.addr !== a || e.data !== d) begin
            sb_fail++;
            $display("FAIL %s: got kind=%0d addr=%h data=%h, required kind=%0d addr=%h data=%h",
                     name, k, a, d, e.kind, e.addr, e.data);
         end
      end
   endtask

   // Monitor: sample on the falling edge, away from the active edge
   always @(negedge clk) begin
      if (reset) begin
         if (csr_wen || csr_jtype != 2'b00) begin
            sb_n++;
            if (csr_wen && csr_jtype != 2'b00) begin
               sb_fail++;
               $display("FAIL wen_with_jtype: got wen=%b jtype=%b, required not both", csr_wen, csr_jtype);
            end
         end
         if (csr_wen) sb_check(0, csr_waddr, csr_wdata, "csr_write");
         if (csr_jtype != 2'b00) sb_check(1, 12'h0, {30'b0, csr_jtype}, "csr_cause");
         if (redirect_valid && redirect_ready) sb_check(2, 12'h0, redirect_pc, "redirect");
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic chk_rst_outs(input string tag);
      chk({tag, "_ctl"}, {25'b0, trap_ready, busy, csr_wen, csr_ren, redirect_valid, csr_jtype},
          32'h0000_0040);
      chk({tag, "_addr"}, {8'b0, csr_waddr, csr_raddr}, 32'h0);
      chk({tag, "_wdata"}, csr_wdata, 32'h0);
      chk({tag, "_rpc"}, redirect_pc, 32'h0);
   endtask

   task automatic csr_load(input logic [11:0] a, input logic [31:0] d);
      ld_addr = a;
      ld_data = d;
      ld_en   = 1'b1;
      @(posedge clk);
      #1 ld_en = 1'b0;
   endtask

   // Entered #1 after a rising edge; returns #1 after the acceptance edge.
   task automatic issue(input logic [1:0] t, input logic [31:0] pc);
      $display("trap issue: type=%b pc=%h", t, pc);
      trap_valid = 1'b1;
      trap_type  = t;
      trap_pc    = pc;
      @(negedge clk);
      chk("trap_ready_idle", {31'b0, trap_ready}, 32'd1);
      @(posedge clk);
      #1;
      trap_valid = 1'b0;
      trap_type  = 2'b00;
   endtask

   // Counts cycles after acceptance until redirect_valid is seen (bounded)
   task automatic wait_redir(input int exp_lat, input string name);
      int cnt;
      cnt = 0;
      while (1) begin
         @(negedge clk);
         cnt++;
         if (redirect_valid || cnt >= 20) break;
      end
      chk(name, cnt, exp_lat);
   endtask

   task automatic wait_idle(input string name);
      int cnt;
      cnt = 0;
      while (1) begin
         @(negedge clk);
         cnt++;
         if (!busy || cnt >= 40) break;
      end
      chk(name, {31'b0, busy}, 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      reset          = 1'b0;
      trap_valid     = 1'b0;
      trap_type      = 2'b00;
      trap_pc        = 32'h0;
      redirect_ready = 1'b1;
      ld_en          = 1'b0;
      ld_addr        = 12'h0;
      ld_data        = 32'h0;

      // Reset state, during and after reset
      repeat (2) @(posedge clk);
      #1 chk_rst_outs("in_reset");
      reset = 1'b1;
      @(posedge clk);
      #1 chk_rst_outs("after_reset");

      // ecall
      csr_load(12'h300, 32'h0000_1808);
      csr_load(12'h305, 32'h8000_0101);
      csr_load(12'h341, 32'h0);
      csr_load(12'h342, 32'h0);
      push(0, 12'h341, 32'h8000_0010);
      push(1, 12'h000, 32'd1);
      push(0, 12'h300, 32'h0000_1880);
      push(2, 12'h000, 32'h8000_0100);
      issue(2'b01, 32'h8000_0010);
      wait_redir(6, "ecall_latency");
      @(posedge clk);
      #1 chk("ecall_idle", {30'b0, busy, trap_ready}, 32'd1);
      chk("ecall_mepc", m_mepc, 32'h8000_0010);
      chk("ecall_mcause", m_mcause, 32'd11);
      chk("ecall_mstatus", m_mstatus, 32'h0000_1880);

      // mret
      csr_load(12'h341, 32'h8000_0014);
      csr_load(12'h300, 32'h0000_1880);
      push(0, 12'h300, 32'h0000_1888);
      push(2, 12'h000, 32'h8000_0014);
      issue(2'b10, 32'h8000_0050);
      wait_redir(4, "mret_latency");
      @(posedge clk);
      #1 chk("mret_idle", {30'b0, busy, trap_ready}, 32'd1);
      chk("mret_mstatus", m_mstatus, 32'h0000_1888);

      // Backpressure on the redirect
      csr_load(12'h300, 32'h0000_1880);
      redirect_ready = 1'b0;
      push(0, 12'h300, 32'h0000_1888);
      push(2, 12'h000, 32'h8000_0014);
      issue(2'b10, 32'h8000_0060);
      wait_redir(4, "bp_latency");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid_hold", {31'b0, redirect_valid}, 32'd1);
         chk("bp_pc_hold", redirect_pc, 32'h8000_0014);
      end
      @(posedge clk);
      #1 redirect_ready = 1'b1;
      @(negedge clk);
      chk("bp_busy_before", {31'b0, busy}, 32'd1);
      @(posedge clk);
      #1 chk("bp_idle_after", {30'b0, busy, trap_ready}, 32'd1);

      // trap_type 11 is ignored in IDLE
      $display("trap issue: type=11 pc=80000040 (ignored)");
      trap_valid = 1'b1;
      trap_type  = 2'b11;
      trap_pc    = 32'h8000_0040;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("ign11_idle", {30'b0, busy, trap_ready}, 32'd1);
      end
      @(posedge clk);
      #1 trap_valid = 1'b0;
      trap_type = 2'b00;
      @(negedge clk);
      chk("ign11_still_idle", {30'b0, busy, trap_ready}, 32'd1);
      @(posedge clk);
      #1;

      // A second ecall while busy must not be taken
      csr_load(12'h300, 32'h0000_1808);
      push(0, 12'h341, 32'h8000_0020);
      push(1, 12'h000, 32'd1);
      push(0, 12'h300, 32'h0000_1880);
      push(2, 12'h000, 32'h8000_0100);
      issue(2'b01, 32'h8000_0020);
      trap_valid = 1'b1;
      trap_type  = 2'b01;
      trap_pc    = 32'h9000_0000;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("busy_not_ready", {30'b0, busy, trap_ready}, 32'd2);
      end
      @(posedge clk);
      #1 trap_valid = 1'b0;
      trap_type = 2'b00;
      wait_idle("busy_ecall_done");
      repeat (3) @(posedge clk);
      #1 chk("busy_ecall_idle", {31'b0, busy}, 32'd0);
      chk("busy_ecall_mepc", m_mepc, 32'h8000_0020);

      // Async reset in W_STAT aborts the sequence
      csr_load(12'h300, 32'h0000_1808);
      csr_load(12'h342, 32'h0);
      push(0, 12'h341, 32'h8000_0030);
      push(1, 12'h000, 32'd1);
      issue(2'b01, 32'h8000_0030);
      repeat (3) @(posedge clk);
      #1 chk("in_wstat", {19'b0, busy, csr_wen, csr_waddr}, {19'b0, 1'b1, 1'b1, 12'h300});
      #1 reset = 1'b0;
      #1 chk_rst_outs("async_rst");
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (8) @(posedge clk);
      #1 chk("rst_idle", {30'b0, busy, trap_ready}, 32'd1);
      chk("rst_mstatus_kept", m_mstatus, 32'h0000_1808);
      chk("rst_mepc", m_mepc, 32'h8000_0030);
      chk("rst_mcause", m_mcause, 32'd11);

      chk("queue_empty", exp_q.size(), 32'd0);
      n_vec  = n_vec + sb_n;
      n_fail = n_fail + sb_fail;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/ysyx_25040111_trap_seq.md
YSYX_25040111_TRAP_SEQ -- requirements
Module: ysyx_25040111_trap_seq

Interface
REQ-001 SHALL have parameter TVEC_MASK, default 32'hFFFF_FFFC, ANDed with the mtvec read value to form the trap target.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 SHALL have port trap_valid  input  1  trap request from decode.
REQ-005 SHALL have port trap_type  input  2  request kind: 01 = ecall, 10 = mret, 00/11 = none.
REQ-006 SHALL have port trap_pc  input  32  PC of the trapping instruction.
REQ-007 SHALL have port trap_ready  output  1  request accepted this cycle when high with trap_valid.
REQ-008 SHALL have port csr_wen  output  1  CSR write enable.
REQ-009 SHALL have port csr_waddr  output  12  CSR write address.
REQ-010 SHALL have port csr_wdata  output  32  CSR write data.
REQ-011 SHALL have port csr_ren  output  1  CSR read enable.
REQ-012 SHALL have port csr_raddr  output  12  CSR read address.
REQ-013 SHALL have port csr_rdata  input  32  combinational CSR read data for csr_raddr.
REQ-014 SHALL have port csr_jtype  output  2  CSR trap-cause strobe; 01 sets mcause = 11.
REQ-015 SHALL have port redirect_valid  output  1  new fetch PC is available.
REQ-016 SHALL have port redirect_pc  output  32  new fetch PC.
REQ-017 SHALL have port redirect_ready  input  1  fetch accepts the redirect.
REQ-018 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-019 SHALL implement a Moore FSM with states IDLE, W_EPC, W_CAUSE, R_STAT, W_STAT, R_VEC, R_EPC, REDIR; all outputs SHALL be decoded from the state and internal registers only.
REQ-020 SHALL drive trap_ready = 1 only in IDLE.
REQ-021 SHALL accept a request on a rising edge where the state is IDLE, trap_valid = 1 and trap_type is 01 or 10; on acceptance it SHALL latch trap_pc and trap_type.
REQ-022 SHALL ignore trap_type 00 or 11 in IDLE and remain in IDLE.
REQ-023 ecall path SHALL be IDLE -> W_EPC -> W_CAUSE -> R_STAT -> W_STAT -> R_VEC -> REDIR, one cycle per state except REDIR.
REQ-024 mret path SHALL be IDLE -> R_EPC -> R_STAT -> W_STAT -> REDIR.
REQ-025 W_EPC SHALL drive csr_wen = 1, csr_waddr = 12'h341, csr_wdata = latched PC.
REQ-026 W_CAUSE SHALL drive csr_jtype = 01 and csr_wen = 0.
REQ-027 R_STAT SHALL drive csr_ren = 1, csr_raddr = 12'h300, and capture csr_rdata into an mstatus register.
REQ-028 W_STAT SHALL drive csr_wen = 1, csr_waddr = 12'h300, csr_wdata = the modified mstatus.
REQ-029 ecall modification: bit7 (MPIE) <= bit3 (MIE); bit3 <= 0; bits[12:11] (MPP) <= 2'b11; all other bits unchanged.
REQ-030 mret modification: bit3 <= bit7; bit7 <= 1; bits[12:11] <= 2'b11; all other bits unchanged.
REQ-031 R_VEC SHALL drive csr_ren = 1, csr_raddr = 12'h305, and capture csr_rdata & TVEC_MASK as the target.
REQ-032 R_EPC SHALL drive csr_ren = 1, csr_raddr = 12'h341, and capture csr_rdata unmasked as the target.
REQ-033 REDIR SHALL hold redirect_valid = 1 and redirect_pc = target stable until redirect_ready = 1, then return to IDLE on that edge.
REQ-034 SHALL never assert csr_wen and a nonzero csr_jtype in the same cycle.
REQ-035 Outside the states listed above, csr_wen, csr_ren and csr_jtype SHALL be 0, and csr_waddr, csr_raddr and csr_wdata SHALL be 0.
REQ-036 Latency from the acceptance edge to the first cycle with redirect_valid high SHALL be 6 cycles for ecall and 4 cycles for mret.
REQ-037 trap_valid received while busy SHALL be ignored; decode is responsible for holding it until trap_ready.

Reset
REQ-038 reset = 0 SHALL immediately force IDLE and clear all internal registers, aborting any sequence in flight; no further CSR write or redirect from that sequence SHALL occur.
REQ-039 Output values during and after reset: trap_ready = 1; busy, csr_wen, csr_ren and redirect_valid = 0; csr_jtype = 00; every address and data output = 0.

Verification
REQ-040 Bench SHALL check ecall: mstatus = 32'h0000_1808, mtvec = 32'h8000_0101, pc = 32'h8000_0010 -> mepc = 32'h8000_0010; mcause = 11; mstatus = 32'h0000_1880; redirect_pc = 32'h8000_0100 six cycles after acceptance.
REQ-041 Bench SHALL check mret: mepc = 32'h8000_0014, mstatus = 32'h0000_1880 -> mstatus = 32'h0000_1888; redirect_pc = 32'h8000_0014 four cycles after acceptance.
REQ-042 Bench SHALL check backpressure: redirect_ready held 0 for 5 cycles in REDIR -> redirect_valid and redirect_pc stay stable; IDLE is entered one edge after redirect_ready = 1.
REQ-043 Bench SHALL check async reset asserted in W_STAT -> outputs take their reset values at once; mstatus keeps its pre-write value.
REQ-044 Bench SHALL check trap_type 11 with trap_valid = 1 in IDLE, and a new ecall issued while busy -> neither is accepted; no CSR activity results.
